ula_fx_arb: RTL and testbench
=============================

Name: ula_fx_arb

Overview:
Round-robin arbiter and sequencer that shares one ula_fx instance between NREQ requesters (e.g. processor core, DMA-style coprocessor, debug port). It accepts one operation per grant, drives the ALU from registered operands, and holds multi-cycle ops (DIV/MOD) for a configurable latency. It captures out/is_zero and returns them on a per-requester response handshake. It sits between the requesters and the ula_fx op/in1/in2/out/is_zero pins.

Parameters:
NUBITS, 32, data width; must match the shared ula_fx
NREQ, 4, number of requesters, 2..8
NRQW, 2, requester index width; 2**NRQW >= NREQ
DIV_LAT, 1, cycles EXEC is held for op 4 (DIV) and 5 (MOD), 1..16

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld  in  NREQ  per-requester operation valid
req_op  in  5*NREQ  packed opcodes; requester i at [5*i+4:5*i]
req_in1  in  NUBITS*NREQ  packed operand 1
req_in2  in  NUBITS*NREQ  packed operand 2
req_rdy  out  NREQ  one-hot accept; req_vld&req_rdy = transfer
alu_op  out  5  to ula_fx op
alu_in1  out  NUBITS  to ula_fx in1
alu_in2  out  NUBITS  to ula_fx in2
alu_out  in  NUBITS  from ula_fx out
alu_zero  in  1  from ula_fx is_zero
rsp_vld  out  NREQ  one-hot response valid
rsp_rdy  in  NREQ  per-requester response accept
rsp_out  out  NUBITS  result
rsp_zero  out  1  captured is_zero
rsp_err  out  1  illegal opcode flag
gnt_id  out  NRQW  index of current owner; valid outside IDLE

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, rr pointer 0, req_rdy 0, rsp_vld 0, rsp_out 0, rsp_zero 0, rsp_err 0, alu_op 0 (NOP), alu_in1/alu_in2 0, gnt_id 0, latency counter 0.
- Reset in any state aborts the in-flight op, and all outputs take reset values next edge. Dropped ops are not replayed.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_rdy is combinational. It is one-hot on the first asserted req_vld searching from the rr pointer upward, with wrap-around.
  - On transfer: latch op/in1/in2 into registers and gnt_id <= winner.
  - If op <= 23, go to EXEC. If op >= 24, set rsp_err=1, rsp_out=0, rsp_zero=0 and go directly to RESP; the ALU is never driven.
  - alu_op=0, alu_in1/alu_in2=0 while in IDLE.
- EXEC:
  - alu_op/alu_in1/alu_in2 are driven from the operand registers.
  - Ops other than 4/5: one cycle. On that edge capture alu_out to rsp_out and alu_zero to rsp_zero, with rsp_err=0, then go to RESP.
  - Ops 4/5: the counter loads DIV_LAT-1 on entry. Capture occurs on the edge where the counter is 0. Inputs stay stable for the whole EXEC period (multicycle path).
- RESP:
  - rsp_vld[gnt_id]=1 (registered). rsp_out, rsp_zero and rsp_err are held stable.
  - On rsp_rdy[gnt_id]: rsp_vld goes to 0 next edge, rr pointer <= (gnt_id+1) mod NREQ, go to IDLE.
  - rsp_rdy bits of other requesters are ignored.
  - alu_op returns to 0 in RESP.
- Throughput: at most one op per 3 cycles (IDLE, EXEC, RESP). req_rdy is 0 in EXEC and RESP.
- req_vld may be withdrawn before acceptance without effect. Requesters with req_vld=0 are skipped. Indices >= NREQ are never granted.
- Latency from accept edge to rsp_vld high: 2 cycles, or DIV_LAT+1 for DIV/MOD, or 1 for an illegal opcode.
- Arithmetic is untouched by the arbiter; widths pass straight through.

Optional Feature:
ULA_FX_ARB_PRIO_EN:
- Defined: requester 0 is fixed highest priority. If req_vld[0]=1 in IDLE it wins regardless of the rr pointer. Remaining requesters use round-robin, and a grant to requester 0 does not update the rr pointer.
- Undefined: pure round-robin for all requesters.

Test Plan:
1. Reset, then req 0 sends ADD (op 2) with in1=5, in2=7 -> req_rdy[0]=1 in the accept cycle; 2 cycles later rsp_vld[0]=1, rsp_out=12, rsp_zero=0, rsp_err=0.
2. All 4 req_vld held high with distinct SUB-free ADD operands, rsp_rdy tied high -> grant order 0,1,2,3,0 and each rsp_vld appears only on the matching bit.
3. DIV_LAT=4, req 1 sends DIV (op 4) 100/7 -> alu_in1/alu_in2 stable for 4 EXEC cycles; rsp_vld[1] 5 cycles after accept with rsp_out=14.
4. req 2 sends op=25 -> rsp_err=1, rsp_out=0, rsp_vld[2] 1 cycle after accept; alu_op stays 0 throughout.
5. EQU (op 17) with 3,3 -> rsp_out=1. Hold rsp_rdy low for 5 cycles -> rsp_vld held and no new req_rdy. Assert rst during a later EXEC -> all outputs at reset values next cycle and the pointer is back at 0.
6. ULA_FX_ARB_PRIO_EN defined, req 0 and req 2 continuously valid -> requester 0 is granted every time. After req_vld[0] drops, requester 2 is granted.

Source files
------------

// File: rtl/ula_fx_arb.sv
// ula_fx_arb: round-robin arbiter/sequencer sharing one ula_fx between NREQ requesters.
// One operation is accepted per grant (IDLE -> EXEC -> RESP). The ALU is driven from
// registered operands, DIV/MOD are held in EXEC for DIV_LAT cycles, and the captured
// result is returned on the winning requester's response handshake.
//
// Optional feature macro: ULA_FX_ARB_PRIO_EN
//   defined   -> requester 0 has fixed top priority; its grants leave the rr pointer alone
//   undefined -> pure round-robin
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_vld/op/in1/in2          packed per-requester operation requests
//   req_rdy                     one-hot accept (combinational, IDLE only)
//   alu_op/alu_in1/alu_in2      to the shared ula_fx
//   alu_out/alu_zero            from the shared ula_fx
//   rsp_vld/rsp_rdy             per-requester response handshake
//   rsp_out/rsp_zero/rsp_err    captured result, zero flag, illegal-opcode flag
//   gnt_id                      index of current owner (valid outside IDLE)
module ula_fx_arb #(
    parameter int unsigned NUBITS  = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NRQW    = 2,
    parameter int unsigned DIV_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_vld,
    input  logic [5*NREQ-1:0]      req_op,
    input  logic [NUBITS*NREQ-1:0] req_in1,
    input  logic [NUBITS*NREQ-1:0] req_in2,
    output logic [NREQ-1:0]        req_rdy,
    output logic [4:0]             alu_op,
    output logic [NUBITS-1:0]      alu_in1,
    output logic [NUBITS-1:0]      alu_in2,
    input  logic [NUBITS-1:0]      alu_out,
    input  logic                   alu_zero,
    output logic [NREQ-1:0]        rsp_vld,
    input  logic [NREQ-1:0]        rsp_rdy,
    output logic [NUBITS-1:0]      rsp_out,
    output logic                   rsp_zero,
    output logic                   rsp_err,
    output logic [NRQW-1:0]        gnt_id
);

    // Counter holds DIV_LAT-1, at most 15.
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              state_q, state_d;
    logic [NRQW-1:0]     rr_q, rr_d;
    logic [NRQW-1:0]     gnt_q, gnt_d;
    logic [4:0]          op_q, op_d;
    logic [NUBITS-1:0]   in1_q, in1_d, in2_q, in2_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [NUBITS-1:0]   rsp_out_q, rsp_out_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_err_q, rsp_err_d;

    logic                win_found;
    logic [NRQW-1:0]     win_id;
    logic [4:0]          sel_op;
    logic [NUBITS-1:0]   sel_in1, sel_in2;

    function automatic logic [NREQ-1:0] onehot(input logic [NRQW-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!win_found && req_vld[idx]) begin
                win_found = 1'b1;
                win_id    = NRQW'(idx);
            end
        end
`ifdef ULA_FX_ARB_PRIO_EN
        if (req_vld[0]) begin
            win_found = 1'b1;
            win_id    = '0;
        end
`endif
    end

    assign sel_op  = req_op[5*int'(win_id) +: 5];
    assign sel_in1 = req_in1[NUBITS*int'(win_id) +: NUBITS];
    assign sel_in2 = req_in2[NUBITS*int'(win_id) +: NUBITS];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        cnt_d      = cnt_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_out_d  = rsp_out_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        req_rdy    = '0;
        alu_op     = '0;
        alu_in1    = '0;
        alu_in2    = '0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_rdy = onehot(win_id);
                    gnt_d   = win_id;
                    op_d    = sel_op;
                    in1_d   = sel_in1;
                    in2_d   = sel_in2;
                    if (sel_op >= 5'd24) begin
                        // Illegal opcode: answer immediately, ALU untouched.
                        rsp_err_d  = 1'b1;
                        rsp_out_d  = '0;
                        rsp_zero_d = 1'b0;
                        rsp_vld_d  = onehot(win_id);
                        state_d    = StResp;
                    end else begin
                        cnt_d   = (sel_op == 5'd4 || sel_op == 5'd5) ? CW'(DIV_LAT - 1) : '0;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                alu_op  = op_q;
                alu_in1 = in1_q;
                alu_in2 = in2_q;
                if (cnt_q == '0) begin
                    rsp_out_d  = alu_out;
                    rsp_zero_d = alu_zero;
                    rsp_err_d  = 1'b0;
                    rsp_vld_d  = onehot(gnt_q);
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_rdy[gnt_q]) begin
                    rsp_vld_d = '0;
                    state_d   = StIdle;
`ifdef ULA_FX_ARB_PRIO_EN
                    if (gnt_q != '0)
`endif
                    rr_d = (gnt_q == NRQW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            gnt_q      <= '0;
            op_q       <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            cnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_out_q  <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            op_q       <= op_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            cnt_q      <= cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_out_q  <= rsp_out_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_out  = rsp_out_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_err  = rsp_err_q;
    assign gnt_id   = gnt_q;

endmodule

// File: tb/tb_ula_fx_arb.sv
// Self-checking bench for ula_fx_arb with a small behavioural ula_fx model and a
// scoreboard of expected responses. Built with DIV_LAT=4, NREQ=4.
module tb_ula_fx_arb;

    localparam int NUBITS  = 32;
    localparam int NREQ    = 4;
    localparam int NRQW    = 2;
    localparam int DIV_LAT = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_vld;
    logic [5*NREQ-1:0]      req_op;
    logic [NUBITS*NREQ-1:0] req_in1;
    logic [NUBITS*NREQ-1:0] req_in2;
    logic [NREQ-1:0]        req_rdy;
    logic [4:0]             alu_op;
    logic [NUBITS-1:0]      alu_in1;
    logic [NUBITS-1:0]      alu_in2;
    logic [NUBITS-1:0]      alu_out;
    logic                   alu_zero;
    logic [NREQ-1:0]        rsp_vld;
    logic [NREQ-1:0]        rsp_rdy;
    logic [NUBITS-1:0]      rsp_out;
    logic                   rsp_zero;
    logic                   rsp_err;
    logic [NRQW-1:0]        gnt_id;

    always #5 clk = ~clk;

    ula_fx_arb #(
        .NUBITS (NUBITS),
        .NREQ   (NREQ),
        .NRQW   (NRQW),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_op  (req_op),
        .req_in1 (req_in1),
        .req_in2 (req_in2),
        .req_rdy (req_rdy),
        .alu_op  (alu_op),
        .alu_in1 (alu_in1),
        .alu_in2 (alu_in2),
        .alu_out (alu_out),
        .alu_zero(alu_zero),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_out (rsp_out),
        .rsp_zero(rsp_zero),
        .rsp_err (rsp_err),
        .gnt_id  (gnt_id)
    );

    // Minimal ula_fx stand-in: ADD=2, DIV=4, MOD=5, EQU=17.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            5'd2:  alu_out = alu_in1 + alu_in2;
            5'd4:  alu_out = (alu_in2 != 0) ? alu_in1 / alu_in2 : '0;
            5'd5:  alu_out = (alu_in2 != 0) ? alu_in1 % alu_in2 : '0;
            5'd17: alu_out = (alu_in1 == alu_in2) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    typedef struct {
        int          id;
        logic [31:0] out;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        req_vld = '0;
        rsp_rdy = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[5*i +: 5]            = op;
        req_in1[NUBITS*i +: NUBITS] = a;
        req_in2[NUBITS*i +: NUBITS] = b;
        req_vld[i]                  = 1'b1;
    endtask

    task automatic wait_rsp(input int max, output int cyc);
        cyc = 0;
        while (rsp_vld == '0 && cyc < max) begin
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        req_op  = '0;
        req_in1 = '0;
        req_in2 = '0;
        do_reset;
        checks++;
        if ({rsp_vld, rsp_err, rsp_zero, gnt_id, req_rdy} !== '0) begin
            failures++;
            $display("FAIL reset_ctl got vld=%b err=%b zero=%b gnt=%0d rdy=%b want all 0",
                     rsp_vld, rsp_err, rsp_zero, gnt_id, req_rdy);
        end
        checks++;
        if (rsp_out !== '0 || alu_op !== '0 || alu_in1 !== '0 || alu_in2 !== '0) begin
            failures++;
            $display("FAIL reset_data got out=%0d op=%0d in1=%0d in2=%0d want 0",
                     rsp_out, alu_op, alu_in1, alu_in2);
        end
    endtask

    task automatic test_add;
        do_reset;
        set_req(0, 5'd2, 32'd5, 32'd7);
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL add_rdy got %b want 0001", req_rdy);
        end
        sb.push_back('{0, 32'd12, 1'b0, 1'b0});
        tick;
        req_vld = '0;
        checks++;
        if (alu_op !== 5'd2 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || rsp_vld !== '0) begin
            failures++;
            $display("FAIL add_exec got op=%0d in1=%0d in2=%0d vld=%b want 2/5/7/0000",
                     alu_op, alu_in1, alu_in2, rsp_vld);
        end
        tick;
        checks++;
        if (rsp_vld !== 4'b0001 || alu_op !== '0 || gnt_id !== 2'd0) begin
            failures++;
            $display("FAIL add_rsp got vld=%b op=%0d gnt=%0d want 0001/0/0",
                     rsp_vld, alu_op, gnt_id);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_out, rsp_zero, rsp_err} !== {e.out, e.zero, e.err}) begin
            failures++;
            $display("FAIL add_data got out=%0d zero=%b err=%b want out=%0d zero=%b err=%b",
                     rsp_out, rsp_zero, rsp_err, e.out, e.zero, e.err);
        end
        rsp_rdy = 4'b0001;
        tick;
        rsp_rdy = '0;
        checks++;
        if (rsp_vld !== '0) begin
            failures++;
            $display("FAIL add_release got vld=%b want 0000", rsp_vld);
        end
    endtask

    task automatic test_back_to_back;
        int exp_id;
        do_reset;
        for (int i = 0; i < NREQ; i++) set_req(i, 5'd2, 32'(10*i + 1), 32'(i + 2));
        rsp_rdy = '1;
        for (int g = 0; g < 5; g++) begin
`ifdef ULA_FX_ARB_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % NREQ;
`endif
            #1;
            checks++;
            if (req_rdy !== (4'b0001 << exp_id)) begin
                failures++;
                $display("FAIL b2b_rdy[%0d] got %b want id %0d", g, req_rdy, exp_id);
            end
            sb.push_back('{exp_id, 32'(11*exp_id + 3), 1'b0, 1'b0});
            tick;
            tick;
            e = sb.pop_front();
            checks++;
            if (rsp_vld !== (4'b0001 << e.id) || gnt_id !== 2'(e.id)) begin
                failures++;
                $display("FAIL b2b_vld[%0d] got vld=%b gnt=%0d want id %0d",
                         g, rsp_vld, gnt_id, e.id);
            end
            checks++;
            if ({rsp_out, rsp_zero, rsp_err} !== {e.out, e.zero, e.err}) begin
                failures++;
                $display("FAIL b2b_data[%0d] got out=%0d zero=%b err=%b want out=%0d",
                         g, rsp_out, rsp_zero, rsp_err, e.out);
            end
            tick;
        end
        req_vld = '0;
        rsp_rdy = '0;
    endtask

    task automatic test_div;
        int cyc;
        do_reset;
        set_req(1, 5'd4, 32'd100, 32'd7);
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin
            failures++;
            $display("FAIL div_rdy got %b want 0010", req_rdy);
        end
        sb.push_back('{1, 32'd14, 1'b0, 1'b0});
        tick;
        req_vld = '0;
        for (int c = 1; c <= DIV_LAT; c++) begin
            checks++;
            if (alu_op !== 5'd4 || alu_in1 !== 32'd100 || alu_in2 !== 32'd7 || rsp_vld !== '0)
            begin
                failures++;
                $display("FAIL div_hold[%0d] got op=%0d in1=%0d in2=%0d vld=%b want 4/100/7/0",
                         c, alu_op, alu_in1, alu_in2, rsp_vld);
            end
            tick;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_vld !== 4'b0010 || {rsp_out, rsp_zero, rsp_err} !== {e.out, e.zero, e.err})
        begin
            failures++;
            $display("FAIL div_rsp got vld=%b out=%0d zero=%b err=%b want 0010 out=%0d",
                     rsp_vld, rsp_out, rsp_zero, rsp_err, e.out);
        end
        rsp_rdy = 4'b0010;
        tick;
        rsp_rdy = '0;
        // Zero-result modulo checks zero capture and the same latency.
        set_req(3, 5'd5, 32'd14, 32'd7);
        #1;
        sb.push_back('{3, 32'd0, 1'b1, 1'b0});
        tick;
        req_vld = '0;
        wait_rsp(20, cyc);
        checks++;
        if (cyc + 1 !== DIV_LAT + 1) begin
            failures++;
            $display("FAIL mod_latency got %0d want %0d", cyc + 1, DIV_LAT + 1);
        end
        e = sb.pop_front();
        checks++;
        if (rsp_vld !== 4'b1000 || {rsp_out, rsp_zero, rsp_err} !== {e.out, e.zero, e.err})
        begin
            failures++;
            $display("FAIL mod_rsp got vld=%b out=%0d zero=%b err=%b want 1000 out=0 zero=1",
                     rsp_vld, rsp_out, rsp_zero, rsp_err);
        end
        rsp_rdy = 4'b1000;
        tick;
        rsp_rdy = '0;
    endtask

    task automatic test_illegal;
        do_reset;
        set_req(2, 5'd25, 32'd9, 32'd9);
        #1;
        checks++;
        if (req_rdy !== 4'b0100 || alu_op !== '0) begin
            failures++;
            $display("FAIL ill_rdy got rdy=%b op=%0d want 0100/0", req_rdy, alu_op);
        end
        sb.push_back('{2, 32'd0, 1'b0, 1'b1});
        tick;
        req_vld = '0;
        e = sb.pop_front();
        checks++;
        if (rsp_vld !== 4'b0100 || alu_op !== '0 ||
            {rsp_out, rsp_zero, rsp_err} !== {e.out, e.zero, e.err}) begin
            failures++;
            $display("FAIL ill_rsp got vld=%b op=%0d out=%0d zero=%b err=%b want 0100/0/0/0/1",
                     rsp_vld, alu_op, rsp_out, rsp_zero, rsp_err);
        end
        rsp_rdy = 4'b0100;
        tick;
        rsp_rdy = '0;
    endtask

    task automatic test_hold_and_abort;
        do_reset;
        set_req(0, 5'd17, 32'd3, 32'd3);
        #1;
        sb.push_back('{0, 32'd1, 1'b0, 1'b0});
        tick;
        req_vld = '0;
        tick;
        set_req(1, 5'd2, 32'd4, 32'd4);
        set_req(2, 5'd2, 32'd1, 32'd1);
        set_req(3, 5'd2, 32'd1, 32'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rsp_vld !== 4'b0001 || req_rdy !== '0 || rsp_out !== 32'd1) begin
                failures++;
                $display("FAIL hold[%0d] got vld=%b rdy=%b out=%0d want 0001/0000/1",
                         c, rsp_vld, req_rdy, rsp_out);
            end
            tick;
        end
        rsp_rdy = 4'b1110;
        tick;
        e = sb.pop_front();
        checks++;
        if (rsp_vld !== 4'b0001 || {rsp_out, rsp_zero, rsp_err} !== {e.out, e.zero, e.err})
        begin
            failures++;
            $display("FAIL hold_other_rdy got vld=%b out=%0d want 0001 out=%0d",
                     rsp_vld, rsp_out, e.out);
        end
        rsp_rdy = 4'b0001;
        tick;
        rsp_rdy = '0;
        req_vld = 4'b0010;
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin
            failures++;
            $display("FAIL abort_rdy got %b want 0010", req_rdy);
        end
        tick;
        req_vld = '0;
        checks++;
        if (alu_op !== 5'd2 || gnt_id !== 2'd1) begin
            failures++;
            $display("FAIL abort_exec got op=%0d gnt=%0d want 2/1", alu_op, gnt_id);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({rsp_vld, rsp_err, rsp_zero, gnt_id, alu_op} !== '0 || rsp_out !== '0 ||
            alu_in1 !== '0 || alu_in2 !== '0) begin
            failures++;
            $display("FAIL abort_reset got vld=%b out=%0d op=%0d gnt=%0d want all 0",
                     rsp_vld, rsp_out, alu_op, gnt_id);
        end
        set_req(0, 5'd2, 32'd1, 32'd1);
        req_vld = 4'b1111;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL abort_ptr got %b want 0001", req_rdy);
        end
        req_vld = '0;
        tick;
    endtask

    task automatic test_prio;
        int exp_id;
        do_reset;
        set_req(0, 5'd2, 32'd1, 32'd1);
        set_req(2, 5'd2, 32'd2, 32'd2);
        rsp_rdy = '1;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) begin
                req_vld[0] = 1'b0;
                exp_id     = 2;
            end else begin
`ifdef ULA_FX_ARB_PRIO_EN
                exp_id = 0;
`else
                exp_id = (g % 2 == 1) ? 2 : 0;
`endif
            end
            #1;
            checks++;
            if (req_rdy !== (4'b0001 << exp_id)) begin
                failures++;
                $display("FAIL prio_rdy[%0d] got %b want id %0d", g, req_rdy, exp_id);
            end
            sb.push_back('{exp_id, 32'(exp_id + 2), 1'b0, 1'b0});
            tick;
            tick;
            e = sb.pop_front();
            checks++;
            if (rsp_vld !== (4'b0001 << e.id) || rsp_out !== e.out) begin
                failures++;
                $display("FAIL prio_rsp[%0d] got vld=%b out=%0d want id %0d out=%0d",
                         g, rsp_vld, rsp_out, e.id, e.out);
            end
            tick;
        end
        req_vld = '0;
        rsp_rdy = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        req_vld = '0;
        rsp_rdy = '0;
        test_reset;
        test_add;
        test_back_to_back;
        test_div;
        test_illegal;
        test_hold_and_abort;
        test_prio;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
